// File: rtl/calc_pio_pkg.sv
// Shared definitions for the calculator input PIO: register map, capture modes and CSR request payload.
package calc_pio_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr;
  } csr_req_t;

  // Single-bit edge qualifier; an unknown mode never captures.
  function automatic logic edge_bit(input logic cur, input logic prev, input edge_type_e mode);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_ANY:  hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/calc_pio_debounce.sv
// Per-bit input conditioner: 2-flop synchroniser plus an optional stable-count debouncer.
// Debouncer is built only when CALC_PIO_DEBOUNCE_EN is defined.
module calc_pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_async,
  output logic out_bit
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("calc_pio_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], in_async};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef CALC_PIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;

  // Flip only after the synchronised level has disagreed for DEBOUNCE_CYCLES straight cycles.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign out_bit = deb_q;
`else
  assign out_bit = sync_q[1];
`endif

endmodule

// File: rtl/calc_pio_in_irq.sv
// Avalon-MM input PIO with synchronised inputs, sticky edge capture, per-bit IRQ mask and level IRQ.
// Optional per-bit debouncing is enabled by defining CALC_PIO_DEBOUNCE_EN.
module calc_pio_in_irq
  import calc_pio_pkg::*;
#(
  parameter int unsigned     WIDTH           = 4,
  parameter int unsigned     EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_MASK     = '0,
  parameter int unsigned     DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("calc_pio_in_irq: WIDTH must be in 1..32");
  end

  localparam edge_type_e EDGE_MODE = edge_type_e'(2'(EDGE_TYPE));

  csr_req_t         req_c;
  logic             unused_wdata_c;
  logic [WIDTH-1:0] cond_c;
  logic [WIDTH-1:0] edge_c;
  logic [WIDTH-1:0] clr_c;

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q,  cap_d;
  logic [31:0]      readdata_q, readdata_d;

  assign req_c = '{addr: address, wdata: writedata, wr: chipselect & ~write_n};
  // Write-data bits above WIDTH are deliberately ignored.
  assign unused_wdata_c = ^req_c.wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    calc_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_async (in_port[i]),
      .out_bit  (cond_c[i])
    );
  end

  always_comb begin
    edge_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_c[i] = edge_bit(cond_c[i], prev_q[i], EDGE_MODE);
    end
  end

  // CSR update: a fresh edge in the same cycle as a clear keeps the capture bit set.
  always_comb begin
    prev_d = cond_c;
    mask_d = mask_q;
    clr_c  = '0;
    if (req_c.wr && req_c.addr == ADDR_MASK) begin
      mask_d = req_c.wdata[WIDTH-1:0];
    end
    if (req_c.wr && req_c.addr == ADDR_EDGE) begin
      clr_c = req_c.wdata[WIDTH-1:0];
    end
    cap_d = (cap_q & ~clr_c) | edge_c;
  end

  always_comb begin
    readdata_d = '0;
    case (req_c.addr)
      ADDR_DATA: readdata_d = 32'(cond_c);
      ADDR_RSVD: readdata_d = '0;
      ADDR_MASK: readdata_d = 32'(mask_q);
      ADDR_EDGE: readdata_d = 32'(cap_q);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      mask_q     <= RESET_MASK;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_calc_pio_in_irq.sv
// Self-checking bench for calc_pio_in_irq: rising/falling/any-edge instances on a shared bus.
module tb_calc_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in0, in1, in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  always #5 clk = ~clk;

  calc_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(0), .RESET_MASK(4'b0000), .DEBOUNCE_CYCLES(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

  calc_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(1), .RESET_MASK(4'b0000), .DEBOUNCE_CYCLES(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));

  calc_pio_in_irq #(.WIDTH(4), .EDGE_TYPE(2), .RESET_MASK(4'b0000), .DEBOUNCE_CYCLES(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  vec_t        vt[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Read: expectation queued with the address, compared when readdata appears one cycle later.
  task automatic rd(input logic [1:0] a, input int which, input logic [31:0] exp, input string name);
    logic [31:0] e;
    logic [31:0] act;
    address = a;
    exp_q.push_back(exp);
    tick();
    e   = exp_q.pop_front();
    act = (which == 0) ? rd0 : ((which == 1) ? rd1 : rd2);
    check(name, act, e);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in0 = '0; in1 = '0; in2 = '0;
    repeat (3) tick();
    check("rst_readdata", rd0, 32'h0);
    check("rst_irq", 32'(irq0), 32'h0);
    reset_n = 1'b1;
    tick();

`ifdef CALC_PIO_DEBOUNCE_EN
    address = 2'd0;
    in0 = 4'b0001;
    repeat (5) tick();
    in0 = 4'b0000;
    repeat (15) tick();
    rd(2'd0, 0, 32'h0, "db_glitch_data");
    rd(2'd3, 0, 32'h0, "db_glitch_cap");

    address = 2'd0;
    in0 = 4'b0001;
    repeat (10) tick();
    check("db_not_early", rd0, 32'h0);
    tick();
    check("db_rise_at_10", rd0, 32'h1);
    in0 = 4'b0000;
    repeat (20) tick();
    rd(2'd3, 0, 32'h1, "db_one_capture");
    rd(2'd0, 0, 32'h0, "db_fall_data");

    wr(2'd3, 32'hF);
    address = 2'd0;
    in0 = 4'b0001;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    check("db_rst_readdata", rd0, 32'h0);
    reset_n = 1'b1;
    repeat (6) tick();
    rd(2'd3, 0, 32'h0, "db_rst_cap");
    rd(2'd0, 0, 32'h0, "db_rst_count_cleared");
    repeat (5) tick();
    rd(2'd0, 0, 32'h1, "db_rst_recount");
`else
    in0 = 4'b1010;
    repeat (5) tick();
    vt[0] = '{addr: 2'd0, exp: 32'h0000000A, name: "read_data"};
    vt[1] = '{addr: 2'd1, exp: 32'h00000000, name: "read_rsvd"};
    vt[2] = '{addr: 2'd2, exp: 32'h00000000, name: "read_mask_rst"};
    vt[3] = '{addr: 2'd3, exp: 32'h0000000A, name: "read_cap_rise"};
    for (int i = 0; i < 4; i++) begin
      rd(vt[i].addr, 0, vt[i].exp, vt[i].name);
    end
    check("irq_masked", 32'(irq0), 32'h0);

    wr(2'd3, 32'hF);
    rd(2'd3, 0, 32'h0, "clear_all");

    in0 = 4'b1011;
    repeat (3) tick();
    check("irq_mask0_pending", 32'(irq0), 32'h0);
    rd(2'd3, 0, 32'h1, "cap_bit0");
    wr(2'd2, 32'h1);
    check("irq_on_mask_write", 32'(irq0), 32'h1);
    wr(2'd3, 32'h1);
    check("irq_off_on_clear", 32'(irq0), 32'h0);
    rd(2'd3, 0, 32'h0, "cap_cleared");

    in0 = 4'b1010;
    repeat (3) tick();
    in0 = 4'b1011;
    repeat (3) tick();
    rd(2'd3, 0, 32'h1, "cap_bit0_again");
    wr(2'd3, 32'hE);
    rd(2'd3, 0, 32'h1, "clear_other_bits");
    check("irq_still_set", 32'(irq0), 32'h1);

    // Bit2 edge lands on the same clock as its clear write.
    in0 = 4'b1111;
    tick();
    tick();
    wr(2'd3, 32'h4);
    rd(2'd3, 0, 32'h5, "edge_beats_clear");

    wr(2'd2, 32'hFFFFFFF4);
    rd(2'd2, 0, 32'h4, "mask_upper_ignored");
    check("irq_bit2", 32'(irq0), 32'h1);
    wr(2'd3, 32'h4);
    check("irq_drop_last", 32'(irq0), 32'h0);
    rd(2'd3, 0, 32'h1, "cap_after_drop");

    wr(2'd0, 32'h0);
    rd(2'd0, 0, 32'hF, "data_read_only");
    wr(2'd1, 32'hFFFF);
    rd(2'd1, 0, 32'h0, "rsvd_write_ignored");

    wr(2'd2, 32'hF);
    check("irq_pre_reset", 32'(irq0), 32'h1);
    in0 = 4'b0000;
    reset_n = 1'b0;
    tick();
    check("irq_in_reset", 32'(irq0), 32'h0);
    reset_n = 1'b1;
    rd(2'd2, 0, 32'h0, "mask_restored");
    rd(2'd3, 0, 32'h0, "cap_discarded");

    in1 = 4'b0001;
    repeat (4) tick();
    rd(2'd3, 1, 32'h0, "fall_ignores_rise");
    in1 = 4'b0000;
    repeat (3) tick();
    rd(2'd3, 1, 32'h1, "fall_capture");

    in2 = 4'b0010;
    repeat (4) tick();
    wr(2'd3, 32'hF);
    in2 = 4'b0000;
    repeat (3) tick();
    rd(2'd3, 2, 32'h2, "any_edge_fall");
    check("irq_any_masked", 32'(irq2), 32'h0);
    check("irq_fall_masked", 32'(irq1), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
